// File: rtl/vga_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : vga_pattern_source
// Purpose  : Self-timed VGA video source. Free-running column/row raster
//            counters drive active-area flags and a selectable RGB test
//            pattern. Everything is registered in one output stage, so sync,
//            counts and video always describe the same pixel.
// Ports    : i_Clk        pixel clock, rising edge
//            i_Rst_L      asynchronous active-low reset
//            i_Pattern    pattern select (0..15), sampled every clock
//            o_HSync      high while output column < ACTIVE_COLS
//            o_VSync      high while output row < ACTIVE_ROWS
//            o_Col_Count  column of the current output pixel
//            o_Row_Count  row of the current output pixel
//            o_Red_Video / o_Grn_Video / o_Blu_Video  colour channels
// Revision : 1.0  initial release
// ============================================================================
module vga_pattern_source #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int CHECK_LOG2  = 5,
  parameter int BORDER      = 2,
  localparam int COL_W      = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1,
  localparam int ROW_W      = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic [3:0]             i_Pattern,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [COL_W-1:0]       o_Col_Count,
  output logic [ROW_W-1:0]       o_Row_Count,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
);

  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [31:0]      C_BAR_W    = 32'(ACTIVE_COLS / 8);

  // Raster counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Output stage
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [COL_W-1:0]       ocol_q;
  logic [ROW_W-1:0]       orow_q;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;

  // Zero-extended copies so pattern bit selects and comparisons stay legal
  // even when CHECK_LOG2 exceeds the counter width.
  logic [31:0] col_ext;
  logic [31:0] row_ext;
  logic [2:0]  bar_idx;
  logic        checker_bit;
  logic        on_border;

  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == C_COL_LAST) begin
      col_d = '0;
      row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  always_comb begin
    col_ext     = 32'(col_q);
    row_ext     = 32'(row_q);
    hsync_d     = (col_ext < 32'(ACTIVE_COLS));
    vsync_d     = (row_ext < 32'(ACTIVE_ROWS));
    bar_idx     = 3'(col_ext / C_BAR_W);
    checker_bit = col_ext[CHECK_LOG2] ^ row_ext[CHECK_LOG2];
    on_border   = (col_ext < 32'(BORDER)) ||
                  (col_ext >= 32'(ACTIVE_COLS - BORDER)) ||
                  (row_ext < 32'(BORDER)) ||
                  (row_ext >= 32'(ACTIVE_ROWS - BORDER));
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    // Blanking overrides every pattern.
    if (hsync_d && vsync_d) begin
      case (i_Pattern)
        4'd1: red_d = '1;
        4'd2: grn_d = '1;
        4'd3: blu_d = '1;
        4'd4: begin
          red_d = {VIDEO_WIDTH{checker_bit}};
          grn_d = {VIDEO_WIDTH{checker_bit}};
          blu_d = {VIDEO_WIDTH{checker_bit}};
        end
        4'd5: begin
          red_d = {VIDEO_WIDTH{bar_idx[2]}};
          grn_d = {VIDEO_WIDTH{bar_idx[1]}};
          blu_d = {VIDEO_WIDTH{bar_idx[0]}};
        end
        4'd6: begin
          red_d = {VIDEO_WIDTH{on_border}};
          grn_d = {VIDEO_WIDTH{on_border}};
          blu_d = {VIDEO_WIDTH{on_border}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      col_q   <= '0;
      row_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      ocol_q  <= '0;
      orow_q  <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      ocol_q  <= col_q;
      orow_q  <= row_q;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
    end
  end

  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Col_Count = ocol_q;
  assign o_Row_Count = orow_q;
  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_source.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pattern_source
// Purpose  : Scoreboard bench for vga_pattern_source on a small 10x6 raster.
//            Stimulus drives i_Pattern and pushes the expected pixel; a
//            monitor pops and compares one entry per output clock.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_pattern_source;
  localparam int VW = 3;
  localparam int TC = 10;
  localparam int TR = 6;
  localparam int AC = 8;
  localparam int AR = 4;
  localparam int CL = 1;
  localparam int BD = 1;
  localparam int CW = $clog2(TC);
  localparam int RW = $clog2(TR);
  localparam int PW = 2 + CW + RW + 3 * VW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    pat = 4'd0;
  logic          hs, vs;
  logic [CW-1:0] colc;
  logic [RW-1:0] rowc;
  logic [VW-1:0] red, grn, blu;

  vga_pattern_source #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR), .CHECK_LOG2(CL), .BORDER(BD)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Pattern(pat),
    .o_HSync(hs), .o_VSync(vs), .o_Col_Count(colc), .o_Row_Count(rowc),
    .o_Red_Video(red), .o_Grn_Video(grn), .o_Blu_Video(blu)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int pix    = 0;   // raster position of the next pixel to be sampled
  bit mon_en = 1'b0;

  function automatic logic [PW-1:0] actual();
    return {hs, vs, colc, rowc, red, grn, blu};
  endfunction

  // Reference: pixel value straight from the pattern definitions.
  function automatic logic [PW-1:0] model(int col, int row, int p);
    int f, r, g, b, k;
    bit act, on;
    f = (1 << VW) - 1;
    r = 0; g = 0; b = 0;
    act = (col < AC) && (row < AR);
    if (act) begin
      case (p)
        1: r = f;
        2: g = f;
        3: b = f;
        4: if ((((col >> CL) & 1) ^ ((row >> CL) & 1)) == 1) begin r = f; g = f; b = f; end
        5: begin
          k = col / (AC / 8);
          r = ((k >> 2) & 1) != 0 ? f : 0;
          g = ((k >> 1) & 1) != 0 ? f : 0;
          b = (k & 1) != 0 ? f : 0;
        end
        6: begin
          on = (col < BD) || (col >= AC - BD) || (row < BD) || (row >= AR - BD);
          if (on) begin r = f; g = f; b = f; end
        end
        default: ;
      endcase
    end
    return {(col < AC), (row < AR), CW'(col), RW'(row), VW'(r), VW'(g), VW'(b)};
  endfunction

  // One pixel: called at a falling edge, returns at the next falling edge.
  task automatic step(input logic [3:0] p);
    pat = p;
    exp_q.push_back(model(pix % TC, pix / TC, int'(p)));
    pix = (pix + 1) % (TC * TR);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (actual() !== '0) begin
      errors++;
      $display("FAIL %s: got %h want 0", name, actual());
    end
  endtask

  // Monitor: the DUT presents a pixel on every clock while out of reset.
  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix: got %h but no expected entry queued", actual());
      end else begin
        logic [PW-1:0] e;
        e = exp_q.pop_front();
        if (actual() !== e) begin
          errors++;
          $display("FAIL pix: col=%0d row=%0d got %h want %h", colc, rowc, actual(), e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    pix = 0;
    mon_en = 1'b1;

    // Full frames of each directed pattern, then an out-of-range code.
    for (int i = 0; i < TC * TR; i++) step(4'd0);
    for (int i = 0; i < TC * TR; i++) step(4'd5);
    for (int i = 0; i < TC * TR; i++) step(4'd1);
    for (int i = 0; i < TC * TR; i++) step(4'd9);
    for (int i = 0; i < TC * TR; i++) step(4'd6);
    for (int i = 0; i < TC * TR; i++) step(4'd4);
    for (int i = 0; i < TC * TR; i++) step(4'd2);

    // Pattern switch 1 -> 3 between columns 3 and 4 of an active row.
    for (int i = 0; i < 2 * TC * TR && !((pix % TC) == 3 && (pix / TC) < AR); i++) step(4'd1);
    step(4'd1);
    step(4'd3);
    step(4'd3);

    // Random patterns, including codes above 7.
    for (int i = 0; i < 300; i++) step(4'($urandom_range(0, 15)));

    // Asynchronous reset with the internal counter at (5,2).
    for (int i = 0; i < 2 * TC * TR && pix != 2 * TC + 5; i++) step(4'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    check_zero("reset_held");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_at_reset: got %0d entries want 0", exp_q.size());
    end
    exp_q.delete();
    rst_n = 1'b1;
    pix = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) step(4'($urandom_range(0, 15)));

    mon_en = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
